// File: rtl/imul_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier controller.
// Holds the FSM state encoding, the default WIDTH/LATENCY values and the requester indices.
// Combinational-only content; nothing here carries state.
package imul_arbiter_pkg;

   typedef enum logic [1:0] {
      IMUL_IDLE = 2'd0,
      IMUL_CALC = 2'd1,
      IMUL_DONE = 2'd2
   } imul_state_t;

   localparam int IMUL_WIDTH   = 16;
   localparam int IMUL_LATENCY = 2;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/IMUL_generate.sv
// Unsigned WIDTH x WIDTH multiplier producing the full 2*WIDTH product.
// Purely combinational; the caller decides how long to let it settle.
// No handshake; the operands are consumed as presented.
module IMUL_generate #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p
);

   // zero-extend both operands so the product is never truncated
   assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/imul_rr_arbiter.sv
// Two-way round-robin select: a lone request wins, a tie goes to the side that did not win last.
// Combinational, zero latency.
// enable low forces both grants low, so the owner of a shared unit can hold off new work.
module imul_rr_arbiter
   import imul_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   input  logic enable,
   output logic gnt0,
   output logic gnt1
);

   // requester 0 wins when alone, or on a tie if requester 1 was served last
   assign gnt0 = enable & req0 & (~req1 | (last == REQ1));
   // requester 1 wins when alone, or on a tie if requester 0 was served last
   assign gnt1 = enable & req1 & (~req0 | (last == REQ0));

endmodule

// File: rtl/imul_arbiter.sv
// Shares one IMUL_generate multiplier between two requesters with round-robin arbitration.
// Grant is combinational in IDLE; the product registers LATENCY cycles after the grant edge.
// The product is held in DONE until its owner acks; other requests wait. Optional IMUL_SIGNED_EN.
module imul_arbiter
   import imul_arbiter_pkg::*;
#(
   parameter int WIDTH   = IMUL_WIDTH,
   parameter int LATENCY = IMUL_LATENCY
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iReq0,
   input  logic [WIDTH-1:0]   iA0,
   input  logic [WIDTH-1:0]   iB0,
   output logic               oGnt0,
   output logic               oValid0,
   input  logic               iAck0,
   input  logic               iReq1,
   input  logic [WIDTH-1:0]   iA1,
   input  logic [WIDTH-1:0]   iB1,
   output logic               oGnt1,
   output logic               oValid1,
   input  logic               iAck1,
`ifdef IMUL_SIGNED_EN
   input  logic               iSigned0,
   input  logic               iSigned1,
`endif
   output logic [2*WIDTH-1:0] oResult,
   output logic               oBusy
);

   imul_state_t          state;
   logic                 owner;
   logic                 last;
   logic [3:0]           cnt;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic [WIDTH-1:0]     sel_a;
   logic [WIDTH-1:0]     sel_b;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   cap;
   logic                 owner_ack;

   imul_rr_arbiter u_arb (
      .req0   (iReq0),
      .req1   (iReq1),
      .last   (last),
      .enable (state == IMUL_IDLE),
      .gnt0   (oGnt0),
      .gnt1   (oGnt1)
   );

   // operands of whichever side is being granted this cycle
   assign sel_a = oGnt1 ? iA1 : iA0;
   assign sel_b = oGnt1 ? iB1 : iB0;

`ifdef IMUL_SIGNED_EN
   logic sel_signed;
   logic neg_a;
   logic neg_b;
   logic neg;

   // signed jobs feed magnitudes to the unsigned multiplier and fix the sign at capture
   assign sel_signed = oGnt1 ? iSigned1 : iSigned0;
   assign neg_a      = sel_signed & sel_a[WIDTH-1];
   assign neg_b      = sel_signed & sel_b[WIDTH-1];
   assign mag_a      = neg_a ? -sel_a : sel_a;
   assign mag_b      = neg_b ? -sel_b : sel_b;
   assign cap        = neg ? -prod : prod;

   // result sign is decided once, when the operands are latched
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
         neg <= 1'b0;
      else if (oGnt0 | oGnt1)
         neg <= neg_a ^ neg_b;
   end
`else
   assign mag_a = sel_a;
   assign mag_b = sel_b;
   assign cap   = prod;
`endif

   IMUL_generate #(.WIDTH(WIDTH)) u_mul (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   assign owner_ack = (owner == REQ0) ? iAck0 : iAck1;
   assign oBusy     = (state != IMUL_IDLE);

   // grant -> settle -> hold-until-ack sequencer with registered result and valids
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state   <= IMUL_IDLE;
         owner   <= REQ0;
         last    <= REQ1;
         cnt     <= 4'd0;
         op_a    <= '0;
         op_b    <= '0;
         oResult <= '0;
         oValid0 <= 1'b0;
         oValid1 <= 1'b0;
      end else begin
         case (state)
            IMUL_IDLE: begin
               if (oGnt0 | oGnt1) begin
                  op_a  <= mag_a;
                  op_b  <= mag_b;
                  owner <= oGnt1 ? REQ1 : REQ0;
                  last  <= oGnt1 ? REQ1 : REQ0;
                  cnt   <= 4'(LATENCY - 1);
                  state <= IMUL_CALC;
               end
            end
            IMUL_CALC: begin
               if (cnt == 4'd0) begin
                  oResult <= cap;
                  oValid0 <= (owner == REQ0);
                  oValid1 <= (owner == REQ1);
                  state   <= IMUL_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            IMUL_DONE: begin
               // leaving through IDLE guarantees a gap cycle before the next grant
               if (owner_ack) begin
                  oValid0 <= 1'b0;
                  oValid1 <= 1'b0;
                  state   <= IMUL_IDLE;
               end
            end
            default: state <= IMUL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imul_arbiter.sv
// Directed bench for imul_arbiter with a cycle-level reference model and literal checkpoints.
// The model predicts grants, valids, busy and the held result from arbitration/timing rules.
// Signed cases only exist when IMUL_SIGNED_EN is defined.
module tb_imul_arbiter;

   localparam int LAT = 2;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        iReq0, iReq1, iAck0, iAck1;
   logic [15:0] iA0, iB0, iA1, iB1;
   logic        oGnt0, oGnt1, oValid0, oValid1, oBusy;
   logic [31:0] oResult;
`ifdef IMUL_SIGNED_EN
   logic        iSigned0, iSigned1;
`endif

   int vectors = 0;
   int miscompares = 0;

   imul_arbiter #(.WIDTH(16), .LATENCY(LAT)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .iReq0   (iReq0),
      .iA0     (iA0),
      .iB0     (iB0),
      .oGnt0   (oGnt0),
      .oValid0 (oValid0),
      .iAck0   (iAck0),
      .iReq1   (iReq1),
      .iA1     (iA1),
      .iB1     (iB1),
      .oGnt1   (oGnt1),
      .oValid1 (oValid1),
      .iAck1   (iAck1),
`ifdef IMUL_SIGNED_EN
      .iSigned0(iSigned0),
      .iSigned1(iSigned1),
`endif
      .oResult (oResult),
      .oBusy   (oBusy)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // reference product: plain integer arithmetic, two's complement when s is set
   function automatic logic [31:0] mul(input logic [15:0] a, input logic [15:0] b, input logic s);
      longint sa, sb, r;
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      r  = sa * sb;
      return r[31:0];
   endfunction

   // ---------------- reference model ----------------
   logic        m_busy, m_owner, m_last;
   int          m_edge, m_grant;
   logic [31:0] m_prod, m_res;
   logic        w_any, w_who;
   logic        s0, s1;

`ifdef IMUL_SIGNED_EN
   assign s0 = iSigned0;
   assign s1 = iSigned1;
`else
   assign s0 = 1'b0;
   assign s1 = 1'b0;
`endif

   // who would win right now if the unit were free
   assign w_any = iReq0 | iReq1;
   assign w_who = (iReq0 & iReq1) ? ~m_last : iReq1;

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         m_busy  <= 1'b0;
         m_owner <= 1'b0;
         m_last  <= 1'b1;
         m_edge  <= 0;
         m_grant <= 0;
         m_prod  <= '0;
         m_res   <= '0;
      end else begin
         m_edge <= m_edge + 1;
         if (m_busy) begin
            if (m_edge == m_grant + LAT) m_res <= m_prod;
            if (m_edge >= m_grant + LAT + 1 && (m_owner ? iAck1 : iAck0)) m_busy <= 1'b0;
         end else if (w_any) begin
            m_busy  <= 1'b1;
            m_owner <= w_who;
            m_last  <= w_who;
            m_grant <= m_edge;
            m_prod  <= w_who ? mul(iA1, iB1, s1) : mul(iA0, iB0, s0);
         end
      end
   end

   // every cycle, mid-period, the DUT must agree with the model
   always @(negedge Clock) begin
      logic vld;
      vld = m_busy && (m_edge > m_grant + LAT);
      chk("m_gnt0",   {31'd0, oGnt0},   {31'd0, !m_busy && w_any && !w_who});
      chk("m_gnt1",   {31'd0, oGnt1},   {31'd0, !m_busy && w_any && w_who});
      chk("m_valid0", {31'd0, oValid0}, {31'd0, vld && !m_owner});
      chk("m_valid1", {31'd0, oValid1}, {31'd0, vld && m_owner});
      chk("m_busy",   {31'd0, oBusy},   {31'd0, m_busy});
      chk("m_result", oResult, m_res);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_valid(input logic who, input int limit);
      int n;
      n = 0;
      while (!(who ? oValid1 : oValid0) && n < limit) begin
         tick();
         n++;
      end
      chk(who ? "valid1_arrives" : "valid0_arrives", {31'd0, who ? oValid1 : oValid0}, 32'd1);
   endtask

   task automatic ack(input logic who);
      if (who) iAck1 = 1'b1; else iAck0 = 1'b1;
      tick();
      iAck0 = 1'b0;
      iAck1 = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      iReq0 = 0; iReq1 = 0; iAck0 = 0; iAck1 = 0;
      iA0 = 0; iB0 = 0; iA1 = 0; iB1 = 0;
`ifdef IMUL_SIGNED_EN
      iSigned0 = 0; iSigned1 = 0;
`endif
      tick();
      tick();
      chk("rst_outputs", {oResult[27:0], oGnt0, oGnt1, oValid0 | oValid1, oBusy}, 32'd0);
      Reset = 1'b1;
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      do_reset();

      // single job 4*5 with exact latency
      iReq0 = 1; iA0 = 16'd4; iB0 = 16'd5;
      #1;
      chk("t1_gnt0", {31'd0, oGnt0}, 32'd1);
      tick();
      iReq0 = 0; iA0 = 0; iB0 = 0;
      chk("t1_calc_novalid", {31'd0, oValid0}, 32'd0);
      chk("t1_busy", {31'd0, oBusy}, 32'd1);
      tick();
      chk("t1_lat_minus1", {31'd0, oValid0}, 32'd0);
      tick();
      chk("t1_valid_at_lat", {31'd0, oValid0}, 32'd1);
      chk("t1_result", oResult, 32'd20);
      ack(1'b0);
      chk("t1_idle_after_ack", {30'd0, oBusy, oValid0}, 32'd0);

      // tie: req0 first, req0 re-requests, req1 then beats it
      do_reset();
      iReq0 = 1; iA0 = 16'd3; iB0 = 16'd7;
      iReq1 = 1; iA1 = 16'hFFFF; iB1 = 16'hFFFF;
      #1;
      chk("t2_tie_gnt", {30'd0, oGnt0, oGnt1}, 32'd2);
      tick();
      iA0 = 16'd6; iB0 = 16'd9;
      wait_valid(1'b0, 10);
      chk("t2_res0", oResult, 32'd21);
      ack(1'b0);
      chk("t2_repeat_gnt", {30'd0, oGnt0, oGnt1}, 32'd1);
      tick();
      iReq1 = 0;
      wait_valid(1'b1, 10);
      chk("t2_res1", oResult, 32'hFFFE0001);
      ack(1'b1);
      chk("t2_gnt0_again", {30'd0, oGnt0, oGnt1}, 32'd2);
      tick();
      iReq0 = 0;
      wait_valid(1'b0, 10);
      chk("t2_res0b", oResult, 32'd54);
      ack(1'b0);

      // owner withholds ack; non-owner ack and request must not disturb
      tick();
      iReq1 = 1; iA1 = 16'h8000; iB1 = 16'd2;
      tick();
      iReq1 = 0;
      wait_valid(1'b1, 10);
      iReq0 = 1; iA0 = 16'd0; iB0 = 16'hFFFF; iAck0 = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_hold_valid", {29'd0, oValid1, oValid0, oGnt0}, 32'd4);
         chk("t3_hold_result", oResult, 32'h00010000);
      end
      iAck0 = 0;
      ack(1'b1);
      chk("t3_pending_gnt0", {30'd0, oGnt0, oGnt1}, 32'd2);
      tick();
      iReq0 = 0;
      wait_valid(1'b0, 10);
      chk("t3_zero_product", oResult, 32'd0);
      ack(1'b0);

      // reset in the middle of CALC
      tick();
      iReq0 = 1; iA0 = 16'd9; iB0 = 16'd9;
      tick();
      iReq0 = 0;
      #2;
      Reset = 1'b0;
      #1;
      chk("t4_async_clear", {oResult[27:0], oGnt0, oGnt1, oValid0 | oValid1, oBusy}, 32'd0);
      tick();
      tick();
      Reset = 1'b1;
      for (int i = 0; i < LAT + 3; i++) begin
         tick();
         chk("t4_no_stale_valid", {30'd0, oValid0, oValid1}, 32'd0);
      end
      iReq0 = 1; iA0 = 16'd2; iB0 = 16'd2;
      tick();
      iReq0 = 0;
      wait_valid(1'b0, 10);
      chk("t4_res", oResult, 32'd4);
      ack(1'b0);

`ifdef IMUL_SIGNED_EN
      tick();
      iReq1 = 1; iSigned1 = 1; iA1 = 16'hFFFC; iB1 = 16'd5;
      tick();
      iReq1 = 0;
      wait_valid(1'b1, 10);
      chk("t5_neg_prod", oResult, 32'hFFFFFFEC);
      ack(1'b1);
      tick();
      iReq1 = 1; iA1 = 16'hFFFD; iB1 = 16'hFFFD;
      tick();
      iReq1 = 0; iSigned1 = 0;
      wait_valid(1'b1, 10);
      chk("t5_pos_prod", oResult, 32'd9);
      ack(1'b1);
`endif

      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
